// File: rtl/updown_scan_pkg.sv
// updown_scan_pkg
// Shared types and defaults for the up/down scan controller.
//   state_t        : controller states (IDLE, UP, DOWN)
//   DEFAULT_WIDTH  : default width of the count and the bounds
//   DEFAULT_NSW_W  : default width of the sweep-count field
package updown_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 3;
    localparam int DEFAULT_NSW_W = 4;

endpackage

// File: rtl/updown_counter_en.sv
// updown_counter_en
// Loadable up/down counter with a count enable.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears q
//   en       : step the count by one this edge
//   up       : step direction (1 = increment, 0 = decrement)
//   load     : load load_val; wins over en
//   load_val : value taken on load
//   q        : current count
module updown_counter_en #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= up ? q + WIDTH'(1) : q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/updown_scan_ctrl.sv
// updown_scan_ctrl
// Sweeps a count back and forth between latched low and high bounds for a
// programmed number of round trips (0 = run until stopped).
// Optional feature macro: UPDOWN_SCAN_PAUSE_EN adds the 'pause' input, which
// freezes the scan while busy.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   start      : scan request, only looked at in IDLE
//   stop       : abort to IDLE (wins over start and pause)
//   pause      : (UPDOWN_SCAN_PAUSE_EN only) freeze count/state/sweeps
//   lo, hi     : bounds, latched on an accepted start (lo < hi required)
//   num_sweeps : round trips to run, latched on an accepted start
//   q          : current scan value
//   dir        : 1 while ascending
//   busy       : 1 in UP or DOWN
//   done       : one-cycle pulse after the final sweep completes
//   err        : one-cycle pulse after a rejected start
//   sweeps     : completed round trips
module updown_scan_ctrl
    import updown_scan_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NSW_W = DEFAULT_NSW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
`ifdef UPDOWN_SCAN_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [NSW_W-1:0] num_sweeps,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NSW_W-1:0] sweeps
);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   hi_r;
    logic [NSW_W-1:0]   nsw_r;
    logic [NSW_W-1:0]   sweeps_r;
    logic               dir_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    logic               hold;
    logic               cnt_en;
    logic               cnt_load;
    logic               accept;
    logic               reject;
    logic               sweep_inc;
    logic               finish;
    logic [WIDTH-1:0]   q_plus;
    logic [WIDTH-1:0]   q_minus;
    logic [NSW_W-1:0]   sweeps_plus;

`ifdef UPDOWN_SCAN_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign q_plus      = q + WIDTH'(1);
    assign q_minus     = q - WIDTH'(1);
    assign sweeps_plus = sweeps_r + NSW_W'(1);

    // The count register itself; the FSM only decides when to load or step it.
    updown_counter_en #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en),
        .up       (state == UP),
        .load     (cnt_load),
        .load_val (lo),
        .q        (q)
    );

    // Next-state and control decode. On the stop edge the step already
    // scheduled for that cycle still completes, then the count holds in IDLE;
    // this can never leave the range because UP is never at hi and DOWN is
    // never at lo. A stop edge does not count a sweep.
    always_comb begin
        state_next = state;
        cnt_en     = 1'b0;
        cnt_load   = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        sweep_inc  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (lo < hi) begin
                        accept     = 1'b1;
                        cnt_load   = 1'b1;
                        state_next = UP;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            UP: begin
                if (stop) begin
                    cnt_en     = 1'b1;
                    state_next = IDLE;
                end else if (!hold) begin
                    cnt_en = 1'b1;
                    if (q_plus == hi_r) begin
                        state_next = DOWN;
                    end
                end
            end
            DOWN: begin
                if (stop) begin
                    cnt_en     = 1'b1;
                    state_next = IDLE;
                end else if (!hold) begin
                    cnt_en = 1'b1;
                    if (q_minus == lo_r) begin
                        sweep_inc = 1'b1;
                        if ((nsw_r != '0) && (sweeps_plus == nsw_r)) begin
                            finish     = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = UP;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched bounds, sweep counter and the registered status outputs.
    // dir and busy are taken from the next state so they line up with q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lo_r     <= '0;
            hi_r     <= '0;
            nsw_r    <= '0;
            sweeps_r <= '0;
            dir_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lo_r     <= lo;
                hi_r     <= hi;
                nsw_r    <= num_sweeps;
                sweeps_r <= '0;
            end else if (sweep_inc) begin
                sweeps_r <= sweeps_plus;
            end
            dir_r  <= (state_next == UP);
            busy_r <= (state_next != IDLE);
            done_r <= finish;
            err_r  <= reject;
        end
    end

    assign dir    = dir_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign sweeps = sweeps_r;

endmodule

// File: doc/updown_scan_ctrl.md
# updown_scan_ctrl

Sequencer that sweeps a WIDTH-bit up/down count back and forth between a programmable low and high bound for a programmed number of round trips. It owns the count register through an enable/load counter sub-module and exposes the count, direction, busy and done to the surrounding design. It sits between the control FSMs that request a scan and the logic consuming the scanned index, for example a display or address stepper.

## Interface
Parameters:
- `WIDTH`, default 3: width of count and bounds.
- `NSW_W`, default 4: width of the sweep-count field.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a scan; sampled only in IDLE.
- `stop` input 1: abort the scan and return to IDLE.
- `lo` input WIDTH: lower bound, latched on an accepted start.
- `hi` input WIDTH: upper bound, latched on an accepted start.
- `num_sweeps` input NSW_W: number of round trips; 0 means run until stop.
- `q` output WIDTH: current scan value.
- `dir` output 1: 1 while ascending, 0 otherwise.
- `busy` output 1: high in UP or DOWN.
- `done` output 1: one-cycle pulse when the final sweep completes.
- `err` output 1: one-cycle pulse when a start is rejected.
- `sweeps` output NSW_W: number of completed round trips.

## Operation
- States:
  - IDLE: hold `q`; accept a start.
  - UP: ascend each cycle.
  - DOWN: descend each cycle.
- IDLE with `start=1`, `stop=0`:
  - If `lo < hi` (unsigned): latch `lo`, `hi` and `num_sweeps`; load `q <= lo`; clear `sweeps`; go to UP.
  - Otherwise: pulse `err`; stay in IDLE; `q` is unchanged.
- UP: `q <= q+1` each cycle. On the edge where `q+1 == hi_r`, also go to DOWN.
- DOWN: `q <= q-1` each cycle. On the edge where `q-1 == lo_r`:
  - Increment `sweeps`.
  - If `num_sweeps_r != 0` and `sweeps+1 == num_sweeps_r`: go to IDLE and pulse `done`.
  - Otherwise: go to UP.
- Each endpoint value is held for exactly one cycle. No step ever wraps; `q` stays within `[lo_r, hi_r]`.
- Continuous mode (`num_sweeps == 0`): `sweeps` wraps modulo 2^NSW_W. `done` never fires.
- `stop` in UP or DOWN: go to IDLE on the next edge; `q` and `sweeps` hold their values; no `done`.
- Simultaneous `start` and `stop` in IDLE: `stop` wins; no load and no `err`.
- `start` while busy is ignored. Bound inputs are ignored except on an accepted start.
- `dir` = (state == UP); `busy` = (state != IDLE). Both are registered.
- Reset at any time, including mid-scan: state IDLE, `q=0`, `sweeps=0`, and `dir`, `busy`, `done`, `err` all 0.

## Timing
- An accepted start at edge k gives `q=lo`, `busy=1` and `dir=1` after edge k.
- `q` reaches `hi_r` after edge k+(hi-lo).
- `q` returns to `lo_r` after edge k+2(hi-lo). One round trip is 2(hi-lo) cycles.
- Final sweep:
  - `done=1` for exactly the cycle after the completing edge.
  - `busy=0` in that same cycle.
  - `q` holds `lo_r` afterward.
- `err` is high for one cycle after the rejecting edge.
- `stop` sampled at edge j gives `busy=0` after edge j.
- The earliest restart is the edge after `done` is seen.

## Configuration
- Macro `UPDOWN_SCAN_PAUSE_EN`.
- Defined:
  - Adds input port `pause` (1 bit).
  - While `pause=1` in UP or DOWN, `q`, state and `sweeps` freeze.
  - `busy` stays 1; `dir` holds its value.
  - `stop` overrides `pause`.
  - `pause` has no effect in IDLE.
- Undefined: the port is absent and behaviour is as described above.

## Structure
- Package `updown_scan_pkg`:
  - State enum (IDLE, UP, DOWN).
  - Default WIDTH and NSW_W constants.
- Sub-module `updown_counter_en`:
  - Ports: `clk`, `rst`, `en`, `up`, `load`, `load_val`, `q`.
  - Synchronous active-high reset; `load` has priority over `en`.
- The FSM, bound registers and sweep counter live in the top module.

## Test plan
- Normal scan: `lo=2`, `hi=5`, `num_sweeps=2`. Required response:
  - `q` = 2,3,4,5,4,3,2,3,4,5,4,3,2.
  - `done` pulses once, 12 edges after start; `sweeps=2`; `busy` then drops.
- Rejected starts: `lo=4`, `hi=4` gives an `err` pulse, `busy` stays 0 and `q` is unchanged. `lo=6`, `hi=1` gives the same.
- Full range: `lo=0`, `hi=7`, `num_sweeps=0`. Required response:
  - `q` never wraps past 7 or 0.
  - `sweeps` increments every 14 cycles; no `done` after 3 trips.
- Abort: `stop` asserted while `q=4` during UP of `lo=1`, `hi=6`. Required response:
  - IDLE next edge; `q` holds 5.
  - A start asserted together with `stop` in IDLE is ignored.
- Reset mid-scan: `rst` asserted during DOWN. Required response:
  - `q=0`, `sweeps=0` and `busy=0` next cycle.
  - A new start then behaves normally.
- Pause (macro defined): `pause` high for 3 cycles at `q=3`. Required response:
  - `q` stays at 3 for those cycles.
  - The sequence then resumes and `done` timing is delayed by exactly 3 cycles.
